// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit instruction-memory and controller interface
interface fetch_unit_if;
  logic        Retire;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRData;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus8;

  modport master (
    input  Retire, PCSrc, BranchTarget, ImemAck, ImemRData,
    output ImemReq, ImemAddr, Instr, InstrValid, PC, PCPlus8
  );

  modport slave (
    output Retire, PCSrc, BranchTarget, ImemAck, ImemRData,
    input  ImemReq, ImemAddr, Instr, InstrValid, PC, PCPlus8
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with one-word prefetch buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic [31:0] pf_data_q, pf_data_d;
  logic        pf_v_q, pf_v_d;

  logic        req;
  logic [31:0] addr;
  logic [31:0] seq_pc;
  logic [31:0] target;

  assign seq_pc = ir_pc_q + 32'd4;
  assign target = bus.BranchTarget & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      fpc_q     <= RESET_PC;
      ir_q      <= 32'h0;
      ir_pc_q   <= RESET_PC;
      pf_data_q <= 32'h0;
      pf_v_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      ir_q      <= ir_d;
      ir_pc_q   <= ir_pc_d;
      pf_data_q <= pf_data_d;
      pf_v_q    <= pf_v_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    ir_d      = ir_q;
    ir_pc_d   = ir_pc_q;
    pf_data_d = pf_data_q;
    pf_v_d    = pf_v_q;
    req       = 1'b0;
    addr      = seq_pc;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        req  = 1'b1;
        addr = fpc_q;
        if (bus.ImemAck) begin
          ir_d    = bus.ImemRData;
          ir_pc_d = fpc_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // The prefetch of ir_pc+4 runs whenever the buffer is empty.
        req = !pf_v_q;
        if (bus.Retire && bus.PCSrc) begin
          fpc_d   = target;
          pf_v_d  = 1'b0;
          state_d = (req && !bus.ImemAck) ? DRAIN : FETCH;
        end else if (bus.Retire && pf_v_q) begin
          ir_d    = pf_data_q;
          ir_pc_d = seq_pc;
          pf_v_d  = 1'b0;
        end else if (bus.Retire && bus.ImemAck) begin
          ir_d    = bus.ImemRData;
          ir_pc_d = seq_pc;
        end else if (bus.Retire) begin
          // FETCH presents the same address, so the pending request carries on.
          fpc_d   = seq_pc;
          state_d = FETCH;
        end else if (req && bus.ImemAck) begin
          pf_data_d = bus.ImemRData;
          pf_v_d    = 1'b1;
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (bus.ImemAck) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ImemReq    = req;
  assign bus.ImemAddr   = addr;
  assign bus.InstrValid = (state_q == HOLD);
  assign bus.Instr      = ir_q;
  assign bus.PC         = ir_pc_q;
  assign bus.PCPlus8    = ir_pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   lat = 0;
  logic [3:0] cnt;

  fetch_unit_if fif();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fif)
  );

  always #5 clk = ~clk;

  // Memory model: ack arrives after lat waiting cycles, data is the inverted address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= 4'd0;
    else if (fif.ImemReq && !fif.ImemAck) cnt <= cnt + 4'd1;
    else cnt <= 4'd0;
  end

  assign fif.ImemAck   = fif.ImemReq && (int'(cnt) >= lat);
  assign fif.ImemRData = ~fif.ImemAddr;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fif.Retire = 1'b0; fif.PCSrc = 1'b0; fif.BranchTarget = 32'h0;
    @(negedge clk);
    total++; if (fif.ImemReq !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", fif.ImemReq); end
    total++; if (fif.InstrValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", fif.InstrValid); end
    total++; if (fif.Instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", fif.Instr); end
    total++; if (fif.PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", fif.PC); end
    total++; if (fif.PCPlus8 !== 32'h8) begin bad++; $display("FAIL reset_pc8 got=%h want=8", fif.PCPlus8); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] e;
    lat = 0; fif.Retire = 1'b1; fif.PCSrc = 1'b0;
    do_reset();
    @(negedge clk);
    total++; if (fif.ImemReq !== 1'b1) begin bad++; $display("FAIL zw_req_c1 got=%b want=1", fif.ImemReq); end
    total++; if (fif.InstrValid !== 1'b0) begin bad++; $display("FAIL zw_valid_c1 got=%b want=0", fif.InstrValid); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = 32'(4 * k);
      total++; if (fif.InstrValid !== 1'b1) begin bad++; $display("FAIL zw_valid k=%0d got=%b want=1", k, fif.InstrValid); end
      total++; if (fif.PC !== e) begin bad++; $display("FAIL zw_pc k=%0d got=%h want=%h", k, fif.PC, e); end
      total++; if (fif.PCPlus8 !== e + 32'd8) begin bad++; $display("FAIL zw_pc8 k=%0d got=%h want=%h", k, fif.PCPlus8, e + 32'd8); end
      total++; if (fif.Instr !== ~e) begin bad++; $display("FAIL zw_instr k=%0d got=%h want=%h", k, fif.Instr, ~e); end
    end
  endtask

  task automatic test_slow_mem();
    logic [31:0] exp_pc, prev_addr;
    logic prev_req, prev_ack, prev_valid;
    int run, pulses;
    exp_pc = 32'h0; prev_addr = 32'h0; prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0;
    run = 0; pulses = 0;
    lat = 2; fif.Retire = 1'b1; fif.PCSrc = 1'b0;
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (prev_req && !prev_ack) begin
        total++; if (fif.ImemReq !== 1'b1 || fif.ImemAddr !== prev_addr) begin bad++; $display("FAIL slow_addr_stable i=%0d got=%b/%h want=1/%h", i, fif.ImemReq, fif.ImemAddr, prev_addr); end
      end
      if (fif.ImemReq) run++;
      if (fif.ImemReq && fif.ImemAck) begin
        total++; if (run !== 3) begin bad++; $display("FAIL slow_req_cycles i=%0d got=%0d want=3", i, run); end
        run = 0;
      end
      if (fif.InstrValid) begin
        total++; if (fif.PC !== exp_pc) begin bad++; $display("FAIL slow_pc i=%0d got=%h want=%h", i, fif.PC, exp_pc); end
        total++; if (prev_valid !== 1'b0) begin bad++; $display("FAIL slow_pulse i=%0d got=%b want=0", i, prev_valid); end
        exp_pc = exp_pc + 32'd4;
        pulses++;
      end
      prev_req = fif.ImemReq; prev_ack = fif.ImemAck; prev_addr = fif.ImemAddr; prev_valid = fif.InstrValid;
    end
    total++; if (pulses !== 5) begin bad++; $display("FAIL slow_pulses got=%0d want=5", pulses); end
  endtask

  task automatic test_prefetch_stall();
    lat = 0; fif.Retire = 1'b0; fif.PCSrc = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    total++; if (fif.InstrValid !== 1'b1 || fif.PC !== 32'h0) begin bad++; $display("FAIL stall_hold got=%b/%h want=1/0", fif.InstrValid, fif.PC); end
    for (int k = 0; k < 4; k++) begin
      total++; if (fif.ImemReq !== 1'b0) begin bad++; $display("FAIL stall_req k=%0d got=%b want=0", k, fif.ImemReq); end
      @(negedge clk);
    end
    fif.Retire = 1'b1;
    @(negedge clk);
    total++; if (fif.InstrValid !== 1'b1 || fif.PC !== 32'h4) begin bad++; $display("FAIL stall_next got=%b/%h want=1/4", fif.InstrValid, fif.PC); end
    total++; if (fif.Instr !== ~32'h4) begin bad++; $display("FAIL stall_instr got=%h want=%h", fif.Instr, ~32'h4); end
    @(negedge clk);
    total++; if (fif.PC !== 32'h8) begin bad++; $display("FAIL stall_after got=%h want=8", fif.PC); end
  endtask

  task automatic test_branch_full();
    lat = 0; fif.Retire = 1'b0; fif.PCSrc = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    total++; if (fif.ImemReq !== 1'b0) begin bad++; $display("FAIL bf_full got=%b want=0", fif.ImemReq); end
    fif.Retire = 1'b1; fif.PCSrc = 1'b1; fif.BranchTarget = 32'h0000_0103;
    @(negedge clk);
    fif.PCSrc = 1'b0; fif.BranchTarget = 32'h0;
    total++; if (fif.InstrValid !== 1'b0) begin bad++; $display("FAIL bf_bubble got=%b want=0", fif.InstrValid); end
    total++; if (fif.ImemReq !== 1'b1 || fif.ImemAddr !== 32'h100) begin bad++; $display("FAIL bf_addr got=%b/%h want=1/100", fif.ImemReq, fif.ImemAddr); end
    @(negedge clk);
    total++; if (fif.InstrValid !== 1'b1 || fif.PC !== 32'h100) begin bad++; $display("FAIL bf_target got=%b/%h want=1/100", fif.InstrValid, fif.PC); end
    total++; if (fif.Instr !== ~32'h100) begin bad++; $display("FAIL bf_instr got=%h want=%h", fif.Instr, ~32'h100); end
    @(negedge clk);
    total++; if (fif.PC !== 32'h104) begin bad++; $display("FAIL bf_seq got=%h want=104", fif.PC); end
  endtask

  task automatic test_branch_drain();
    bit found;
    lat = 2; fif.Retire = 1'b0; fif.PCSrc = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    total++; if (fif.InstrValid !== 1'b1 || fif.ImemReq !== 1'b1) begin bad++; $display("FAIL dr_pre got=%b/%b want=1/1", fif.InstrValid, fif.ImemReq); end
    fif.Retire = 1'b1; fif.PCSrc = 1'b1; fif.BranchTarget = 32'h0000_0200;
    @(negedge clk);
    fif.PCSrc = 1'b0; fif.BranchTarget = 32'h0;
    total++; if (fif.InstrValid !== 1'b0 || fif.ImemReq !== 1'b1 || fif.ImemAddr !== 32'h4) begin bad++; $display("FAIL dr_drain got=%b/%b/%h want=0/1/4", fif.InstrValid, fif.ImemReq, fif.ImemAddr); end
    @(negedge clk);
    total++; if (fif.InstrValid !== 1'b0) begin bad++; $display("FAIL dr_ack_cycle got=%b want=0", fif.InstrValid); end
    @(negedge clk);
    total++; if (fif.InstrValid !== 1'b0 || fif.ImemAddr !== 32'h200) begin bad++; $display("FAIL dr_refetch got=%b/%h want=0/200", fif.InstrValid, fif.ImemAddr); end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (fif.InstrValid) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL dr_timeout got=0 want=1"); end
    total++; if (fif.PC !== 32'h200 || fif.Instr !== ~32'h200) begin bad++; $display("FAIL dr_target got=%h/%h want=200/%h", fif.PC, fif.Instr, ~32'h200); end
  endtask

  task automatic test_reset_async();
    lat = 2; fif.Retire = 1'b1; fif.PCSrc = 1'b0;
    do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (fif.ImemReq !== 1'b0 || fif.InstrValid !== 1'b0) begin bad++; $display("FAIL ar_midreq got=%b/%b want=0/0", fif.ImemReq, fif.InstrValid); end
    @(negedge clk);
    lat = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (fif.InstrValid !== 1'b1 || fif.PC !== 32'h0) begin bad++; $display("FAIL ar_restart got=%b/%h want=1/0", fif.InstrValid, fif.PC); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (fif.InstrValid !== 1'b0 || fif.ImemReq !== 1'b0 || fif.PC !== 32'h0) begin bad++; $display("FAIL ar_hold got=%b/%b/%h want=0/0/0", fif.InstrValid, fif.ImemReq, fif.PC); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (fif.InstrValid !== 1'b1 || fif.PC !== 32'h0) begin bad++; $display("FAIL ar_restart2 got=%b/%h want=1/0", fif.InstrValid, fif.PC); end
  endtask

  task automatic test_wrap();
    lat = 0; fif.Retire = 1'b1; fif.PCSrc = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    fif.PCSrc = 1'b1; fif.BranchTarget = 32'hFFFF_FFFF;
    @(negedge clk);
    fif.PCSrc = 1'b0; fif.BranchTarget = 32'h0;
    total++; if (fif.ImemAddr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_addr got=%h want=fffffffc", fif.ImemAddr); end
    @(negedge clk);
    total++; if (fif.PC !== 32'hFFFF_FFFC || fif.PCPlus8 !== 32'h4) begin bad++; $display("FAIL wr_top got=%h/%h want=fffffffc/4", fif.PC, fif.PCPlus8); end
    @(negedge clk);
    total++; if (fif.InstrValid !== 1'b1 || fif.PC !== 32'h0 || fif.Instr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wr_wrap got=%b/%h/%h want=1/0/ffffffff", fif.InstrValid, fif.PC, fif.Instr); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_slow_mem();
    test_prefetch_stall();
    test_branch_full();
    test_branch_drain();
    test_reset_async();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end for the ARM single-cycle core. It is the producer side of the controller's instruction interface.
- Fetches words from a handshaked instruction memory and presents `Instr`, `PC` and `PCPlus8` to the controller/datapath.
- Consumes the controller's `PCSrc` together with the branch target.
- Holds a one-word prefetch buffer so that sequential instructions can retire back-to-back. Branches flush the buffer and drain any in-flight request.

Parameters:
- `RESET_PC`, 32'h00000000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk` input 1 — core clock, rising edge.
- `reset` input 1 — asynchronous, active-high reset.
- `Retire` input 1 — datapath has executed the presented instruction this cycle; ignored unless `InstrValid`=1.
- `PCSrc` input 1 — controller PC-select for the retiring instruction; 1 = take `BranchTarget`.
- `BranchTarget` input 32 — ALU result used as the new PC; bits [1:0] are forced to 0 internally.
- `ImemReq` output 1 — instruction memory read request.
- `ImemAddr` output 32 — word-aligned read address.
- `ImemAck` input 1 — read data valid, completes the request; may be asserted in the same cycle as `ImemReq`.
- `ImemRData` input 32 — read data, sampled when `ImemReq` && `ImemAck`.
- `Instr` output 32 — instruction presented to the controller.
- `InstrValid` output 1 — `Instr`/`PC` are valid; downstream write enables must be qualified with this signal.
- `PC` output 32 — address of `Instr`.
- `PCPlus8` output 32 — `PC`+8 (R15 read value).

Behaviour:
- Registers:
  - `state` ∈ {IDLE, FETCH, HOLD, DRAIN}
  - `fpc`[31:0], `ir`[31:0], `ir_pc`[31:0], `pf_data`[31:0], `pf_v`
- Reset values (asynchronous):
  - `state`=IDLE, `fpc`=`RESET_PC`, `ir`=0, `ir_pc`=`RESET_PC`, `pf_data`=0, `pf_v`=0.
  - Hence `ImemReq`=0, `InstrValid`=0, `Instr`=0, `PC`=`RESET_PC`, `PCPlus8`=`RESET_PC`+8.
- Output decoding:
  - `InstrValid`=1 only in HOLD.
  - `Instr`=`ir`, `PC`=`ir_pc`, `PCPlus8`=`ir_pc`+8, all modulo 2^32.
- `ImemReq`:
  - 1 in FETCH and DRAIN.
  - 1 in HOLD only when `pf_v`=0.
  - 0 in IDLE.
- `ImemAddr`:
  - `fpc` in FETCH.
  - `ir_pc`+4 in HOLD and DRAIN.
  - Stable from assertion of `ImemReq` until the ack cycle.
  - Once asserted, `ImemReq` is never withdrawn before ack, except by reset.
- IDLE:
  - Always goes to FETCH on the next cycle.
- FETCH:
  - On ack: `ir`←`ImemRData`, `ir_pc`←`fpc`, go to HOLD.
  - Otherwise stay.
- HOLD, evaluated in the following order each cycle (at most one retire per cycle):
  1. `Retire`&`PCSrc`:
     - `fpc`←{`BranchTarget`[31:2],2'b00}, `pf_v`←0.
     - If a request is outstanding without ack this cycle: go to DRAIN.
     - Else go to FETCH (any ack data this cycle is discarded).
  2. `Retire`&!`PCSrc`&`pf_v`:
     - `ir`←`pf_data`, `ir_pc`←`ir_pc`+4, `pf_v`←0, stay in HOLD (back-to-back issue).
  3. `Retire`&!`PCSrc`&!`pf_v`&ack:
     - `ir`←`ImemRData`, `ir_pc`←`ir_pc`+4, stay in HOLD.
  4. `Retire`&!`PCSrc`&!`pf_v`&!ack:
     - `fpc`←`ir_pc`+4, go to FETCH. The address is unchanged, so the request continues seamlessly.
  5. !`Retire`&ack:
     - `pf_data`←`ImemRData`, `pf_v`←1.
- DRAIN:
  - `InstrValid`=0.
  - On ack: discard the data, go to FETCH at `fpc`.
- Latency and throughput:
  - With a zero-wait memory (ack same cycle as request), the first valid instruction appears 2 cycles after reset release.
  - Sequential code then retires every cycle.
  - A taken branch costs 1 bubble cycle (FETCH), plus the drain time if a prefetch is in flight.
- Wrap-around: `ir_pc`+4 from 32'hFFFFFFFC wraps to 0. No error is flagged.
- Reset mid-request: the request is abandoned and `ImemReq` drops immediately. The memory is reset by the same signal.

Test Plan:
- Zero-wait memory, `RESET_PC`=0, `Retire` held 1, `PCSrc`=0:
  - `ImemReq`=1 at cycle 1 after reset release.
  - `InstrValid` from cycle 2.
  - `PC` sequence 0, 4, 8, 12…, one instruction per cycle.
  - `PCPlus8`=`PC`+8.
- Memory with 3-cycle ack latency, `Retire`=1:
  - `ImemAddr` is constant for all 3 request cycles.
  - `InstrValid` pulses once per completed fetch.
  - No address is skipped or duplicated.
- `Retire`=0 while in HOLD:
  - The prefetch of `PC`+4 completes and `pf_v`=1.
  - `ImemReq` then stays 0.
  - When `Retire` rises, the next cycle presents `PC`+4 with no bubble.
- Taken branch with the prefetch buffer full: `PCSrc`=1, `BranchTarget`=32'h00000103.
  - `InstrValid`=0 for one cycle.
  - `ImemAddr`=32'h00000100.
  - Next `PC`=32'h100; the buffered word is never presented.
- Taken branch while a prefetch is outstanding (slow memory):
  - Enters DRAIN.
  - The late ack data is discarded.
  - The next request goes to the target.
  - `InstrValid` stays 0 until the target word arrives.
- Assert `reset` mid-request and during HOLD:
  - `ImemReq` and `InstrValid` go to 0 asynchronously.
  - After release, fetch restarts at `RESET_PC`.
- With `ir_pc`=32'hFFFFFFFC and sequential retire: the next `PC` is 32'h00000000.
